// File: rtl/seq_arith_unit.sv
// Sequential unsigned arithmetic unit: add, sub, mul in one cycle,
// div/mod via a restoring shift-subtract divider over WIDTH cycles.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid            (op, a, b captured on accept)
//   in_ready   unit idle, can accept a request
//   op         0 add, 1 sub, 2 mul, 3 div, 4 mod, 5-7 illegal
//   a, b       unsigned operands, WIDTH bits
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   c          result, 2*WIDTH+1 bits
//   err        divide by zero or illegal opcode (qualified by out_valid)
module seq_arith_unit #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH:0]   c,
    output logic               err
);

    localparam int RW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int XW = RW - WIDTH;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // FSM and registered outputs
    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [RW-1:0]     c_q;
    logic              err_q;

    // Divider datapath
    logic [WIDTH-1:0]  divisor_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [CW-1:0]     cnt_q;
    logic              is_mod_q;

    // Single-cycle result path
    logic [RW-1:0]     ax;
    logic [RW-1:0]     bx;
    logic [RW-1:0]     fast_c_d;
    logic              fast_err_d;
    logic              to_calc_d;

    always_comb begin
        ax         = {{XW{1'b0}}, a};
        bx         = {{XW{1'b0}}, b};
        fast_c_d   = '0;
        fast_err_d = 1'b0;
        to_calc_d  = 1'b0;
        case (op)
            OP_ADD: fast_c_d = ax + bx;
            // RW-bit subtraction gives the two's complement wrap directly
            OP_SUB: fast_c_d = ax - bx;
            OP_MUL: fast_c_d = ax * bx;
            OP_DIV,
            OP_MOD: begin
                if (b == '0) begin
                    fast_err_d = 1'b1;
                end else begin
                    to_calc_d = 1'b1;
                end
            end
            default: fast_err_d = 1'b1;
        endcase
    end

    // One restoring step. The dividend lives in quo_q and is shifted
    // out MSB first while quotient bits are shifted in at the bottom.
    logic [WIDTH:0]    rem_shift;
    logic              sub_ok;
    logic [WIDTH-1:0]  rem_d;
    logic [WIDTH-1:0]  quo_d;
    logic [RW-1:0]     div_c_d;
    logic              last_step;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        sub_ok    = rem_shift >= {1'b0, divisor_q};
        // When sub_ok the true difference is below the divisor, so the
        // low WIDTH bits of a modular subtract are exact.
        if (sub_ok) begin
            rem_d = rem_shift[WIDTH-1:0] - divisor_q;
        end else begin
            rem_d = rem_shift[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], sub_ok};
        if (is_mod_q) begin
            div_c_d = {{XW{1'b0}}, rem_d};
        end else begin
            div_c_d = {{XW{1'b0}}, quo_d};
        end
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            err_q       <= 1'b0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            is_mod_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (to_calc_d) begin
                            state_q   <= CALC;
                            divisor_q <= b;
                            quo_q     <= a;
                            rem_q     <= '0;
                            cnt_q     <= '0;
                            is_mod_q  <= (op == OP_MOD);
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            c_q         <= fast_c_d;
                            err_q       <= fast_err_d;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        c_q         <= div_c_d;
                        err_q       <= 1'b0;
                    end
                end
                DONE: begin
                    // Going back through IDLE keeps a consumed cycle
                    // from also accepting the next request.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed testbench for seq_arith_unit (WIDTH = 4).
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_seq_arith_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] c;
    logic       err;

    int checks;
    int errors;

    seq_arith_unit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits for accept, scrambles the inputs, then
    // returns the number of cycles from accept until out_valid.
    task automatic do_req(input logic [2:0] o, input logic [3:0] x,
                          input logic [3:0] y, output int lat);
        int w;
        w = 0;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        op = 3'd0;
        a = ~x;
        b = ~y;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        op = 3'd0;
        a = 4'd3;
        b = 4'd3;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %0b required 0", out_valid);
        end
        checks++;
        if (c !== 9'd0) begin
            errors++;
            $display("FAIL reset_c: got %0d required 0", c);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %0b required 0", err);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_add();
        int lat;
        do_req(3'd0, 4'd14, 4'd12, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL add_latency: got %0d required 1", lat);
        end
        checks++;
        if (c !== 9'd26 || err !== 1'b0) begin
            errors++;
            $display("FAIL add_14_12: c=%0d err=%0b required c=26 err=0", c, err);
        end
        step();
        do_req(3'd0, 4'd15, 4'd15, lat);
        checks++;
        if (c !== 9'd30 || err !== 1'b0) begin
            errors++;
            $display("FAIL add_15_15: c=%0d err=%0b required c=30 err=0", c, err);
        end
        step();
    endtask

    task automatic test_sub_mul();
        int lat;
        do_req(3'd1, 4'd12, 4'd14, lat);
        checks++;
        if (c !== 9'd510 || err !== 1'b0) begin
            errors++;
            $display("FAIL sub_12_14: c=%0d err=%0b required c=510 err=0", c, err);
        end
        step();
        do_req(3'd1, 4'd4, 4'd2, lat);
        checks++;
        if (c !== 9'd2) begin
            errors++;
            $display("FAIL sub_4_2: c=%0d required 2", c);
        end
        step();
        do_req(3'd2, 4'd15, 4'd15, lat);
        checks++;
        if (c !== 9'd225 || err !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL mul_15_15: c=%0d err=%0b lat=%0d required c=225 err=0 lat=1",
                     c, err, lat);
        end
        step();
    endtask

    task automatic test_div_mod();
        int lat;
        do_req(3'd3, 4'd15, 4'd4, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL div_latency: got %0d required 5", lat);
        end
        checks++;
        if (c !== 9'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL div_15_4: c=%0d err=%0b required c=3 err=0", c, err);
        end
        step();
        do_req(3'd4, 4'd15, 4'd4, lat);
        checks++;
        if (c !== 9'd3 || err !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL mod_15_4: c=%0d err=%0b lat=%0d required c=3 err=0 lat=5",
                     c, err, lat);
        end
        step();
        do_req(3'd4, 4'd12, 4'd14, lat);
        checks++;
        if (c !== 9'd12 || err !== 1'b0) begin
            errors++;
            $display("FAIL mod_12_14: c=%0d err=%0b required c=12 err=0", c, err);
        end
        step();
        do_req(3'd3, 4'd13, 4'd1, lat);
        checks++;
        if (c !== 9'd13) begin
            errors++;
            $display("FAIL div_13_1: c=%0d required 13", c);
        end
        step();
        do_req(3'd3, 4'd14, 4'd3, lat);
        checks++;
        if (c !== 9'd4) begin
            errors++;
            $display("FAIL div_14_3: c=%0d required 4", c);
        end
        step();
        do_req(3'd4, 4'd14, 4'd3, lat);
        checks++;
        if (c !== 9'd2) begin
            errors++;
            $display("FAIL mod_14_3: c=%0d required 2", c);
        end
        step();
    endtask

    task automatic test_errors();
        int lat;
        do_req(3'd3, 4'd0, 4'd0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL div0_latency: got %0d required 1", lat);
        end
        checks++;
        if (c !== 9'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL div0: c=%0d err=%0b required c=0 err=1", c, err);
        end
        step();
        do_req(3'd4, 4'd7, 4'd0, lat);
        checks++;
        if (c !== 9'd0 || err !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL mod0: c=%0d err=%0b lat=%0d required c=0 err=1 lat=1",
                     c, err, lat);
        end
        step();
        do_req(3'd6, 4'd9, 4'd3, lat);
        checks++;
        if (c !== 9'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL op6: c=%0d err=%0b required c=0 err=1", c, err);
        end
        step();
        do_req(3'd5, 4'd9, 4'd3, lat);
        checks++;
        if (c !== 9'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL op5: c=%0d err=%0b required c=0 err=1", c, err);
        end
        step();
    endtask

    task automatic test_stall();
        int lat;
        out_ready = 1'b0;
        do_req(3'd2, 4'd4, 4'd2, lat);
        // A pending request held during the stall must wait its turn.
        in_valid = 1'b1;
        op = 3'd0;
        a = 4'd1;
        b = 4'd1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || c !== 9'd8 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: out_valid=%0b c=%0d in_ready=%0b required 1 8 0",
                         i, out_valid, c, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: in_ready=%0b out_valid=%0b required 1 0",
                     in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || c !== 9'd2) begin
            errors++;
            $display("FAIL held_request: out_valid=%0b c=%0d required 1 2",
                     out_valid, c);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        do_req(3'd0, 4'd5, 4'd6, lat);
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: in_ready=%0b out_valid=%0b required 1 0",
                     in_ready, out_valid);
        end
        do_req(3'd2, 4'd3, 4'd7, lat);
        checks++;
        if (c !== 9'd21 || lat !== 1) begin
            errors++;
            $display("FAIL b2b_mul_3_7: c=%0d lat=%0d required c=21 lat=1", c, lat);
        end
        step();
    endtask

    task automatic test_reset_calc();
        int seen;
        in_valid = 1'b1;
        op = 3'd3;
        a = 4'd15;
        b = 4'd1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 9'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_calc: in_ready=%0b out_valid=%0b c=%0d err=%0b required 1 0 0 0",
                     in_ready, out_valid, c, err);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_calc_ghost: out_valid cycles=%0d required 0", seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 3'd0;
        a = 4'd0;
        b = 4'd0;
        test_reset();
        test_add();
        test_sub_mul();
        test_div_mod();
        test_errors();
        test_back_to_back();
        test_stall();
        test_reset_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, 4, operand width in bits; result width RW = 2*WIDTH+1 (9 at default).
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand/opcode request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5-7 illegal.
REQ-008 a  input  WIDTH  unsigned operand A.
REQ-009 b  input  WIDTH  unsigned operand B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 c  output  RW  result.
REQ-013 err  output  1  divide/modulus by zero or illegal opcode; qualified by out_valid.

Function
REQ-014 A request SHALL be accepted on a rising edge where in_valid && in_ready; a, b and op SHALL be captured at that edge and ignored afterward.
REQ-015 FSM states SHALL be IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE -> DONE on accept for op 0, 1, 2, illegal op, or op 3/4 with b==0; out_valid SHALL then be 1 exactly one cycle after accept.
REQ-017 IDLE -> CALC on accept for op 3/4 with b!=0; CALC SHALL run a restoring shift-subtract divider for exactly WIDTH cycles, then go to DONE; out_valid SHALL be 1 exactly WIDTH+1 cycles after accept (5 at default).
REQ-018 DONE -> IDLE on the edge where out_ready==1; c and err SHALL hold stable while out_valid && !out_ready.
REQ-019 A new request SHALL NOT be accepted in the cycle a result is consumed; the earliest next accept is one cycle after leaving DONE.
REQ-020 add: c = zero-extended a + b (max 30 at default, no truncation).
REQ-021 sub: c = (a - b) mod 2^RW, two's complement wrap (4-2=2; 12-14=510).
REQ-022 mul: c = a * b, zero-extended (max 225 at default).
REQ-023 div: c = floor(a/b) zero-extended; mod: c = a mod b zero-extended.
REQ-024 div/mod with b==0: c = 0, err = 1; illegal op: c = 0, err = 1; otherwise err = 0.
REQ-025 in_valid while in_ready==0 SHALL have no effect; the requester holds the request until accepted.

Reset
REQ-026 When rst==1 at a rising edge the FSM SHALL enter IDLE, with in_ready = 1, out_valid = 0, c = 0, err = 0, divider registers cleared, regardless of state.
REQ-027 Reset during CALC or DONE SHALL discard the operation in progress; no out_valid SHALL be produced for it.
REQ-028 in_valid SHALL be ignored in any cycle where rst==1.

Verification
REQ-029 add a=14, b=12, out_ready=1 -> out_valid one cycle after accept, c=26, err=0; then a=15, b=15 -> c=30.
REQ-030 sub a=12, b=14 -> c=510, err=0; mul a=15, b=15 -> c=225.
REQ-031 div a=15, b=4 -> out_valid exactly 5 cycles after accept, c=3; mod a=15, b=4 -> c=3; mod a=12, b=14 -> c=12.
REQ-032 div a=0, b=0 -> one-cycle latency, c=0, err=1; op=6 -> c=0, err=1.
REQ-033 mul a=4, b=2 with out_ready=0 for 6 cycles -> out_valid, c=8 stable all 6 cycles, in_ready=0; out_ready=1 -> next cycle in_ready=1, out_valid=0.
REQ-034 div a=15, b=1 with rst pulsed in 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, c=0, and no result appears afterward.
